// File: rtl/halfip_filter_wr_pkg.sv
// Shared FME definitions: 6-tap half-pel filter taps, shift amount and job FSM encoding.
package halfip_filter_wr_pkg;

  localparam int unsigned NumTaps   = 6;
  localparam int unsigned FiltShift = 5;

  typedef logic [7:0]           pix_t;
  typedef pix_t [NumTaps-1:0]   win_t;   // index 0 is the oldest sample

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRun,
    StDrain,
    StDone
  } state_e;

  function automatic int tap_coef(int idx);
    case (idx)
      0, 5:    return 1;
      1, 4:    return -5;
      2, 3:    return 20;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/halfip_filter_wr_if.sv
// Pixel-in / register-write-out bundle for the half-pel filter writer.
interface halfip_filter_wr_if;
  logic        start;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_addr;
  logic        wr_en;
  logic        busy;
  logic        done;

  modport master (
    output start, pix_in, pix_valid,
    input  pix_ready, wr_data, wr_addr, wr_en, busy, done
  );

  modport slave (
    input  start, pix_in, pix_valid,
    output pix_ready, wr_data, wr_addr, wr_en, busy, done
  );
endinterface

// File: rtl/halfip_tap6.sv
// 6-tap half-pel filter: registered signed sum, then registered round/shift/clip to 0..255.
module halfip_tap6
  import halfip_filter_wr_pkg::*;
#(
  parameter int RND = 16
) (
  input  logic clk,
  input  logic rst,
  input  win_t i_win,
  input  logic i_vld,
  output pix_t o_pix,
  output logic o_vld
);

  int                 w_acc;
  logic signed [15:0] w_sum;
  logic signed [15:0] w_rnd;
  logic signed [15:0] w_shift;
  pix_t               w_clip;

  logic signed [15:0] r_sum;
  logic               r_sum_vld;
  pix_t               r_pix;
  logic               r_pix_vld;

  always_comb begin
    w_acc = 0;
    for (int i = 0; i < NumTaps; i++) begin
      w_acc = w_acc + tap_coef(i) * int'(i_win[i]);
    end
    // |S| <= 42*255, so 16 signed bits hold it without loss
    w_sum = 16'(w_acc);
  end

  always_comb begin
    w_rnd   = r_sum + 16'(RND);
    w_shift = w_rnd >>> FiltShift;
    if (w_shift < 16'sd0) begin
      w_clip = 8'd0;
    end else if (w_shift > 16'sd255) begin
      w_clip = 8'd255;
    end else begin
      w_clip = w_shift[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum     <= '0;
      r_sum_vld <= 1'b0;
      r_pix     <= '0;
      r_pix_vld <= 1'b0;
    end else begin
      r_sum     <= w_sum;
      r_sum_vld <= i_vld;
      r_pix     <= w_clip;
      r_pix_vld <= r_sum_vld;
    end
  end

  assign o_pix = r_pix;
  assign o_vld = r_pix_vld;

endmodule

// File: rtl/halfip_filter_wr.sv
// Half-pel filter job engine: windows incoming pixels, filters them and writes packed 4-sample words.
module halfip_filter_wr
  import halfip_filter_wr_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 16,
  parameter int          RND       = 16
) (
  input  logic               clk,
  input  logic               rst,
  halfip_filter_wr_if.slave  bus
);

  localparam logic [7:0] TotalPix = 8'(4 * NUM_WORDS + NumTaps - 1);
  localparam logic [7:0] FillPix  = 8'(NumTaps - 1);
  localparam logic [3:0] LastAddr = 4'(NUM_WORDS - 1);

  state_e      r_state;
  logic [7:0]  r_pix_cnt;
  logic        r_ready;
  logic        r_busy;
  logic        r_done;

  win_t        r_win;
  logic        r_win_vld;

  logic [1:0]  r_byte_idx;
  logic [23:0] r_acc;
  logic [3:0]  r_word_idx;
  logic [31:0] r_wr_data;
  logic [3:0]  r_wr_addr;
  logic        r_wr_en;

  logic        w_accept;
  logic        w_job_start;
  logic [7:0]  w_pix_cnt_nxt;
  pix_t        w_samp;
  logic        w_samp_vld;

  assign w_accept      = bus.pix_valid & r_ready;
  assign w_job_start   = bus.start & (r_state == StIdle);
  assign w_pix_cnt_nxt = r_pix_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pix_cnt <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_state   <= StFill;
            r_pix_cnt <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        StFill, StRun: begin
          if (w_accept) begin
            r_pix_cnt <= w_pix_cnt_nxt;
            if (w_pix_cnt_nxt == TotalPix) begin
              r_state <= StDrain;
              r_ready <= 1'b0;
            end else if (r_state == StFill && w_pix_cnt_nxt == FillPix) begin
              r_state <= StRun;
            end
          end
        end
        StDrain: begin
          if (r_wr_en && r_wr_addr == LastAddr) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Only pixels accepted in RUN complete a full window and yield a sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win     <= '0;
      r_win_vld <= 1'b0;
    end else begin
      r_win_vld <= w_accept & (r_state == StRun);
      if (w_accept) begin
        r_win <= {bus.pix_in, r_win[NumTaps-1:1]};
      end
    end
  end

  halfip_tap6 #(
    .RND (RND)
  ) u_tap6 (
    .clk   (clk),
    .rst   (rst),
    .i_win (r_win),
    .i_vld (r_win_vld),
    .o_pix (w_samp),
    .o_vld (w_samp_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_idx <= '0;
      r_acc      <= '0;
      r_word_idx <= '0;
      r_wr_data  <= '0;
      r_wr_addr  <= '0;
      r_wr_en    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_job_start) begin
        r_byte_idx <= '0;
        r_word_idx <= '0;
      end else if (w_samp_vld) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          r_wr_data  <= {w_samp, r_acc};
          r_wr_addr  <= r_word_idx;
          r_wr_en    <= 1'b1;
          r_word_idx <= r_word_idx + 4'd1;
        end else begin
          r_acc[{r_byte_idx, 3'b000} +: 8] <= w_samp;
        end
      end
    end
  end

  assign bus.pix_ready = r_ready;
  assign bus.wr_data   = r_wr_data;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_en     = r_wr_en;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_halfip_filter_wr.sv
// Randomized bench for halfip_filter_wr against a pixel-list model of the half-pel filter job.
module tb_halfip_filter_wr;

  localparam int NW  = 16;
  localparam int TOT = 4 * NW + 5;

  typedef struct {
    int          t;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;

  halfip_filter_wr_if bus ();

  halfip_filter_wr #(
    .NUM_WORDS (NW),
    .RND       (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          m_busy = 1'b0;
  int          m_acc  = 0;
  int          m_done_cyc = -1;
  int          done_cnt = 0;
  int          px  [TOT];
  int          mpx [TOT];
  wr_t         q[$];
  logic [31:0] cap_data [NW];
  logic [3:0]  cap_addr [NW];
  int          cap_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Half-pel sample straight from the filter definition, p0 oldest
  function automatic int samp(int a, int b, int c, int d, int e, int f);
    int s;
    s = a - 5 * b + 20 * c + 20 * d - 5 * e + f;
    s = (s + 16) >>> 5;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  function automatic logic [31:0] word_at(int w);
    logic [31:0] r;
    int k;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      k = 4 * w + j;
      r[8*j +: 8] = 8'(samp(mpx[k], mpx[k+1], mpx[k+2], mpx[k+3], mpx[k+4], mpx[k+5]));
    end
    return r;
  endfunction

  // Check outputs of the cycle just ended, then predict the effect of the coming edge
  always @(negedge clk) begin
    bit exp_wr;
    cyc++;
    chk("pix_ready", 32'(bus.pix_ready), 32'(m_busy && m_acc < TOT));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(cyc == m_done_cyc));
    exp_wr = (q.size() > 0) && (q[0].t == cyc);
    chk("wr_en", 32'(bus.wr_en), 32'(exp_wr));
    if (exp_wr) begin
      if (bus.wr_en === 1'b1) begin
        chk("wr_addr", 32'(bus.wr_addr), 32'(q[0].addr));
        chk("wr_data", bus.wr_data, q[0].data);
      end
      void'(q.pop_front());
    end
    if (bus.wr_en === 1'b1 && cap_cnt < NW) begin
      cap_data[cap_cnt] = bus.wr_data;
      cap_addr[cap_cnt] = bus.wr_addr;
      cap_cnt++;
    end
    if (bus.done === 1'b1) done_cnt++;

    if (rst) begin
      m_busy     = 1'b0;
      m_acc      = 0;
      m_done_cyc = -1;
      q.delete();
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy  = 1'b1;
        m_acc   = 0;
        cap_cnt = 0;
      end
    end else begin
      if (bus.pix_valid && m_acc < TOT) begin
        mpx[m_acc] = int'(bus.pix_in);
        if (m_acc >= 8 && (m_acc - 8) % 4 == 0) begin
          q.push_back('{t: cyc + 4, addr: 4'((m_acc - 8) / 4), data: word_at((m_acc - 8) / 4)});
        end
        if (m_acc == TOT - 1) m_done_cyc = cyc + 5;
        m_acc++;
      end
      if (cyc == m_done_cyc) m_busy = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int stall_pct, bit poke);
    bus.pix_valid = (int'($urandom_range(99)) >= stall_pct);
    bus.pix_in    = (m_acc < TOT) ? 8'(px[m_acc]) : 8'($urandom_range(255));
    bus.start     = poke && ($urandom_range(7) == 0);
    step();
  endtask

  task automatic set_px(int kind);
    for (int i = 0; i < TOT; i++) begin
      case (kind)
        0:       px[i] = 100;
        1:       px[i] = i;
        default: px[i] = int'($urandom_range(255));
      endcase
    end
    if (kind == 2) begin
      px[0] = 0;    px[1] = 0;    px[2] = 255;  px[3] = 255;  px[4] = 0;    px[5] = 0;
      px[8] = 255;  px[9] = 255;  px[10] = 0;   px[11] = 0;   px[12] = 255; px[13] = 255;
    end
  endtask

  task automatic run_job(int stall_pct, bit poke);
    int d0;
    int g;
    d0 = done_cnt;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    g = 0;
    while (done_cnt == d0 && g < 4000) begin
      drive(stall_pct, poke);
      g++;
    end
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    chk("job_timeout", 32'(g < 4000), 32'd1);
    repeat (3) step();
  endtask

  task automatic chk_ramp(string tag);
    chk({tag, "_w0"}, cap_data[0], 32'h0605_0403);
    chk({tag, "_a0"}, 32'(cap_addr[0]), 32'd0);
    chk({tag, "_w1"}, cap_data[1], 32'h0A09_0807);
    chk({tag, "_a1"}, 32'(cap_addr[1]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int g;
    logic [31:0] w;

    chk("model_const", 32'(samp(100, 100, 100, 100, 100, 100)), 32'd100);
    chk("model_ramp",  32'(samp(0, 1, 2, 3, 4, 5)), 32'd3);
    chk("model_hi",    32'(samp(0, 0, 255, 255, 0, 0)), 32'd255);
    chk("model_lo",    32'(samp(255, 255, 0, 0, 255, 255)), 32'd0);

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = 8'd0;
    repeat (3) step();
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    rst = 1'b0;
    step();

    set_px(0);
    run_job(0, 1'b0);
    chk("const_count", 32'(cap_cnt), 32'd16);
    for (int i = 0; i < NW; i++) begin
      chk("const_data", cap_data[i], 32'h6464_6464);
      chk("const_addr", 32'(cap_addr[i]), 32'(i));
    end
    chk("done_count1", 32'(done_cnt), 32'd1);

    set_px(1);
    run_job(0, 1'b0);
    chk_ramp("ramp");

    set_px(1);
    run_job(60, 1'b1);
    chk_ramp("ramp_stall");
    chk("done_count3", 32'(done_cnt), 32'd3);

    set_px(2);
    run_job(40, 1'b0);
    w = cap_data[0];
    chk("clip_hi", 32'(w[7:0]), 32'd255);
    w = cap_data[2];
    chk("clip_lo", 32'(w[7:0]), 32'd0);

    repeat (2) begin
      set_px(3);
      run_job(30, 1'b1);
    end
    chk("done_count6", 32'(done_cnt), 32'd6);

    // Abort a job after its third write
    set_px(3);
    d0 = done_cnt;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    g = 0;
    while (cap_cnt < 3 && g < 2000) begin
      drive(20, 1'b0);
      g++;
    end
    chk("abort_writes", 32'(cap_cnt), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_wr_data", bus.wr_data, 32'd0);
    chk("abort_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    repeat (40) drive(0, 1'b0);
    bus.pix_valid = 1'b0;
    chk("abort_no_done", 32'(done_cnt), 32'(d0));

    // start together with rst is dropped
    rst       = 1'b1;
    bus.start = 1'b1;
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (3) step();
    chk("rst_start_busy", 32'(bus.busy), 32'd0);
    chk("rst_start_ready", 32'(bus.pix_ready), 32'd0);

    set_px(1);
    run_job(25, 1'b0);
    chk_ramp("restart");
    chk("restart_count", 32'(cap_cnt), 32'd16);
    chk("restart_done", 32'(done_cnt), 32'(d0 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
